// File: rtl/ibex_hpm_counter_bank.sv
// Bank of NumCounters event-selectable performance counters with sticky overflow flags.
// Optional overflow flags and interrupt are enabled by defining IBEX_HPM_OVF_IRQ_EN.
module ibex_hpm_counter_bank #(
  parameter int NumCounters  = 4,
  parameter int CounterWidth = 40,
  parameter int NumEvents    = 16,
  localparam int IdxW        = (NumCounters > 1) ? $clog2(NumCounters) : 1,
  localparam int EvSelW      = $clog2(NumEvents + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumEvents-1:0]   event_i,
  input  logic [NumCounters-1:0] inhibit_i,
  input  logic                   cfg_we_i,
  input  logic [IdxW-1:0]        cfg_idx_i,
  input  logic [EvSelW-1:0]      cfg_evsel_i,
  input  logic                   cnt_we_i,
  input  logic                   cnth_we_i,
  input  logic [IdxW-1:0]        cnt_idx_i,
  input  logic [31:0]            cnt_wdata_i,
  input  logic [IdxW-1:0]        rd_idx_i,
  output logic [63:0]            rd_val_o,
  output logic [EvSelW-1:0]      rd_evsel_o,
  output logic [NumCounters-1:0] ovf_o,
  input  logic [NumCounters-1:0] ovf_clr_i,
  output logic                   irq_o
);

  logic [CounterWidth-1:0] cnt_q   [NumCounters];
  logic [CounterWidth-1:0] cnt_d   [NumCounters];
  logic [EvSelW-1:0]       evsel_q [NumCounters];
  logic [NumCounters-1:0]  wrap;
  logic                    ev_hit;
  logic                    wr_hit;
  logic [63:0]             wr_val;

  // A CSR write to a channel takes precedence over its increment in the same cycle.
  always_comb begin
    ev_hit = 1'b0;
    wr_hit = 1'b0;
    wr_val = '0;
    wrap   = '0;
    for (int i = 0; i < NumCounters; i++) begin
      cnt_d[i] = cnt_q[i];
      ev_hit   = 1'b0;
      for (int k = 0; k < NumEvents; k++) begin
        if (evsel_q[i] == EvSelW'(k + 1)) ev_hit = event_i[k];
      end
      wr_hit = (cnt_we_i || cnth_we_i) && (cnt_idx_i == IdxW'(i));
      wr_val = 64'(cnt_q[i]);
      if (wr_hit) begin
        if (cnt_we_i)  wr_val[31:0]  = cnt_wdata_i;
        if (cnth_we_i) wr_val[63:32] = cnt_wdata_i;
        cnt_d[i] = CounterWidth'(wr_val);
      end else if (ev_hit && !inhibit_i[i]) begin
        cnt_d[i] = cnt_q[i] + CounterWidth'(1);
        wrap[i]  = &cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumCounters; i++) begin
        cnt_q[i]   <= '0;
        evsel_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumCounters; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (cfg_we_i && (cfg_idx_i == IdxW'(i))) evsel_q[i] <= cfg_evsel_i;
      end
    end
  end

`ifdef IBEX_HPM_OVF_IRQ_EN
  logic [NumCounters-1:0] ovf_q;
  logic                   irq_q;

  // A wrap wins over a simultaneous clear; irq follows the flags one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~ovf_clr_i) | wrap;
      irq_q <= |ovf_q;
    end
  end

  assign ovf_o = ovf_q;
  assign irq_o = irq_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^{ovf_clr_i, wrap};
  assign ovf_o      = '0;
  assign irq_o      = 1'b0;
`endif

  always_comb begin
    rd_val_o   = '0;
    rd_evsel_o = '0;
    for (int i = 0; i < NumCounters; i++) begin
      if (rd_idx_i == IdxW'(i)) begin
        rd_val_o   = 64'(cnt_q[i]);
        rd_evsel_o = evsel_q[i];
      end
    end
  end

endmodule

// File: tb/tb_ibex_hpm_counter_bank.sv
// Scoreboard bench for ibex_hpm_counter_bank: the driver pushes expected read/ovf/irq
// values from a reference model, and a monitor pops and compares after every edge.
module tb_ibex_hpm_counter_bank;

  localparam int NC = 5;
  localparam int CW = 40;
  localparam int NE = 16;
  localparam int IW = 3;
  localparam int EW = 5;
  localparam logic [63:0] MASK = (CW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CW) - 64'd1);

  typedef struct {
    logic [NE-1:0] ev;
    logic [NC-1:0] inh;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [EW-1:0] evsel;
    logic          we;
    logic          weh;
    logic [IW-1:0] cidx;
    logic [31:0]   wdata;
    logic [IW-1:0] ridx;
    logic [NC-1:0] clr;
  } stim_t;

  typedef struct {
    logic [63:0]   val;
    logic [EW-1:0] evsel;
    logic          chk_evsel;
    logic [NC-1:0] ovf;
    logic          irq;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NE-1:0] event_s = '0;
  logic [NC-1:0] inhibit = '0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [EW-1:0] cfg_evsel = '0;
  logic          cnt_we = 1'b0;
  logic          cnth_we = 1'b0;
  logic [IW-1:0] cnt_idx = '0;
  logic [31:0]   cnt_wdata = '0;
  logic [IW-1:0] rd_idx = '0;
  logic [63:0]   rd_val;
  logic [EW-1:0] rd_evsel;
  logic [NC-1:0] ovf;
  logic [NC-1:0] ovf_clr = '0;
  logic          irq;

  int errors = 0;
  int checks = 0;

  exp_t exp_q[$];

  // Reference model state: one counter value, selector and flag per channel.
  logic [63:0]   m_cnt   [NC];
  int            m_evsel [NC];
  logic [NC-1:0] m_ovf;
  logic          m_irq;

  ibex_hpm_counter_bank #(
    .NumCounters (NC),
    .CounterWidth(CW),
    .NumEvents   (NE)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .event_i    (event_s),
    .inhibit_i  (inhibit),
    .cfg_we_i   (cfg_we),
    .cfg_idx_i  (cfg_idx),
    .cfg_evsel_i(cfg_evsel),
    .cnt_we_i   (cnt_we),
    .cnth_we_i  (cnth_we),
    .cnt_idx_i  (cnt_idx),
    .cnt_wdata_i(cnt_wdata),
    .rd_idx_i   (rd_idx),
    .rd_val_o   (rd_val),
    .rd_evsel_o (rd_evsel),
    .ovf_o      (ovf),
    .ovf_clr_i  (ovf_clr),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle(input int ridx);
    stim_t s;
    s = '{ev: '0, inh: '0, cfg_we: 1'b0, cfg_idx: '0, evsel: '0, we: 1'b0, weh: 1'b0,
          cidx: '0, wdata: '0, ridx: IW'(ridx), clr: '0};
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i]   = '0;
      m_evsel[i] = 0;
    end
    m_ovf = '0;
    m_irq = 1'b0;
  endtask

  task automatic modelStep(input stim_t s);
    logic [NC-1:0] wrapped;
    logic [31:0]   lo;
    logic [31:0]   hi;
    logic          any_old;
    wrapped = '0;
    any_old = |m_ovf;
    for (int i = 0; i < NC; i++) begin
      if ((s.we || s.weh) && (int'(s.cidx) == i)) begin
        lo = s.we  ? s.wdata : m_cnt[i][31:0];
        hi = s.weh ? s.wdata : m_cnt[i][63:32];
        m_cnt[i] = {hi, lo} & MASK;
      end else if (m_evsel[i] >= 1 && m_evsel[i] <= NE && s.ev[m_evsel[i]-1] && !s.inh[i]) begin
        if (m_cnt[i] == MASK) begin
          m_cnt[i]   = '0;
          wrapped[i] = 1'b1;
        end else begin
          m_cnt[i] = m_cnt[i] + 64'd1;
        end
      end
    end
    if (s.cfg_we && int'(s.cfg_idx) < NC) m_evsel[s.cfg_idx] = int'(s.evsel);
`ifdef IBEX_HPM_OVF_IRQ_EN
    m_ovf = (m_ovf & ~s.clr) | wrapped;
    m_irq = any_old;
`else
    m_ovf = '0;
    m_irq = 1'b0;
`endif
  endtask

  // Drives one cycle of stimulus and queues the state expected after the next edge.
  task automatic applyStimulus(input stim_t s, input bit do_rst);
    exp_t e;
    @(negedge clk);
    rst_n     = !do_rst;
    event_s   = s.ev;
    inhibit   = s.inh;
    cfg_we    = s.cfg_we;
    cfg_idx   = s.cfg_idx;
    cfg_evsel = s.evsel;
    cnt_we    = s.we;
    cnth_we   = s.weh;
    cnt_idx   = s.cidx;
    cnt_wdata = s.wdata;
    rd_idx    = s.ridx;
    ovf_clr   = s.clr;
    if (do_rst) modelReset();
    else modelStep(s);
    e.chk_evsel = int'(s.ridx) < NC;
    e.val       = e.chk_evsel ? m_cnt[s.ridx] : 64'd0;
    e.evsel     = e.chk_evsel ? EW'(m_evsel[s.ridx]) : '0;
    e.ovf       = m_ovf;
    e.irq       = m_irq;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("rd_val", rd_val, e.val);
        if (e.chk_evsel) checkOutput("rd_evsel", 64'(rd_evsel), 64'(e.evsel));
        checkOutput("ovf", 64'(ovf), 64'(e.ovf));
        checkOutput("irq", 64'(irq), 64'(e.irq));
      end
    end
  end

  initial begin : driver
    stim_t s;
    int    budget;
    modelReset();
    applyStimulus(idle(0), 1'b1);
    applyStimulus(idle(1), 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(idle(i), 1'b0);

    // Channel 0 on event 2 for five pulses.
    s = idle(0); s.cfg_we = 1'b1; s.cfg_idx = 0; s.evsel = 3;
    applyStimulus(s, 1'b0);
    for (int i = 0; i < 5; i++) begin
      s = idle(0); s.ev[2] = 1'b1;
      applyStimulus(s, 1'b0);
    end
    for (int i = 0; i < NC; i++) applyStimulus(idle(i), 1'b0);

    // Channel 1 preset to all-ones then wrapped by one event.
    s = idle(1); s.weh = 1'b1; s.cidx = 1; s.wdata = 32'h0000_00FF;
    s.cfg_we = 1'b1; s.cfg_idx = 1; s.evsel = 1;
    applyStimulus(s, 1'b0);
    s = idle(1); s.we = 1'b1; s.cidx = 1; s.wdata = 32'hFFFF_FFFF;
    applyStimulus(s, 1'b0);
    s = idle(1); s.ev[0] = 1'b1;
    applyStimulus(s, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(idle(1), 1'b0);

    // Write on channel 2 drops its increment; channel 3 still counts.
    s = idle(2); s.cfg_we = 1'b1; s.cfg_idx = 2; s.evsel = 5;
    applyStimulus(s, 1'b0);
    s = idle(3); s.cfg_we = 1'b1; s.cfg_idx = 3; s.evsel = 5;
    applyStimulus(s, 1'b0);
    s = idle(2); s.we = 1'b1; s.cidx = 2; s.wdata = 32'h10; s.ev[4] = 1'b1;
    applyStimulus(s, 1'b0);
    applyStimulus(idle(3), 1'b0);

    // Inhibit channel 0 for four cycles of events, then release.
    for (int i = 0; i < 6; i++) begin
      s = idle(0); s.ev[2] = 1'b1; s.inh[0] = (i < 4);
      applyStimulus(s, 1'b0);
    end

    // Clear the flag, re-wrap channel 1 with a simultaneous clear, then clear alone.
    s = idle(1); s.clr[1] = 1'b1;
    applyStimulus(s, 1'b0);
    applyStimulus(idle(1), 1'b0);
    applyStimulus(idle(1), 1'b0);
    s = idle(1); s.we = 1'b1; s.weh = 1'b1; s.cidx = 1; s.wdata = 32'hFFFF_FFFF;
    applyStimulus(s, 1'b0);
    s = idle(1); s.ev[0] = 1'b1; s.clr[1] = 1'b1;
    applyStimulus(s, 1'b0);
    applyStimulus(idle(1), 1'b0);
    s = idle(1); s.clr[1] = 1'b1;
    applyStimulus(s, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(idle(1), 1'b0);

    // Both halves written at once, then out-of-range writes and config.
    s = idle(4); s.we = 1'b1; s.weh = 1'b1; s.cidx = 4; s.wdata = 32'hA5A5_A5A5;
    applyStimulus(s, 1'b0);
    for (int k = NC; k < 8; k++) begin
      s = idle(k); s.we = 1'b1; s.weh = 1'b1; s.cidx = IW'(k); s.wdata = 32'h1234_5678;
      s.cfg_we = 1'b1; s.cfg_idx = IW'(k); s.evsel = 1;
      applyStimulus(s, 1'b0);
    end
    for (int i = 0; i < 8; i++) applyStimulus(idle(i), 1'b0);

    // Randomised traffic, biased toward near-wrap values to exercise overflow.
    for (int n = 0; n < 600; n++) begin
      s = idle(int'($urandom_range(0, 7)));
      s.ev   = NE'($urandom);
      s.inh  = NC'($urandom & $urandom & $urandom);
      s.clr  = NC'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0) begin
        s.cfg_we  = 1'b1;
        s.cfg_idx = IW'($urandom_range(0, 7));
        s.evsel   = EW'($urandom_range(0, 20));
      end
      s.cidx = IW'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin
        s.we    = 1'b1;
        s.wdata = ($urandom_range(0, 1) == 0) ? $urandom : (32'hFFFF_FFF8 + 32'($urandom_range(0, 7)));
      end
      if ($urandom_range(0, 9) == 0) begin
        s.weh = 1'b1;
        if (!s.we) s.wdata = ($urandom_range(0, 1) == 0) ? $urandom : 32'h0000_00FF;
      end
      applyStimulus(s, 1'b0);
    end

    // Reset in the middle of activity must discard everything.
    applyStimulus(idle(0), 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(idle(i), 1'b0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      #2;
      budget++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
